mux8_rr_arb: RTL and testbench
==============================

MUX8_RR_ARB -- requirements
Module: mux8_rr_arb

Interface
REQ-001 Parameter: MAX_HOLD, 4, maximum consecutive cycles one requester keeps the grant while others wait (legal range 1..255).
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: req  input  8  request lines; bit i = requester i asks for the shared 8-to-1 8-bit mux path.
REQ-005 Port: gnt  output  8  registered one-hot grant; bit i = requester i owns the path.
REQ-006 Port: s  output  3  registered mux select = binary index of current/last owner; drives the 8-to-1 mux select directly.
REQ-007 Port: busy  output  1  registered; 1 while any grant is held.
REQ-008 Port: sw  output  1  registered one-cycle pulse on every cycle in which gnt takes a new non-zero value (new owner).

Function
REQ-009 Two states SHALL exist: IDLE (gnt=0) and OWN (exactly one gnt bit set); gnt SHALL never have more than one bit set.
REQ-010 Round-robin pointer ptr[2:0] SHALL hold the highest-priority index; search order ptr, ptr+1, ... ptr+7 modulo 8 (wrap 7->0).
REQ-011 IDLE, req != 0 at edge: SHALL enter OWN with owner = first set req bit in search order; gnt/s/busy/sw updated at that edge (1-cycle latency req->gnt).
REQ-012 IDLE, req == 0: SHALL stay IDLE; s SHALL hold its previous value so the mux output stays stable.
REQ-013 OWN: hold counter hc SHALL be 0 on the grant edge and increment by 1 each further cycle the same owner keeps the grant, saturating at MAX_HOLD-1.
REQ-014 OWN, req[owner]==0 at edge: grant SHALL release; ptr <= owner+1; if any other req set, new owner chosen per REQ-011 from the updated ptr in the same edge (no idle gap), else IDLE.
REQ-015 OWN, req[owner]==1, hc==MAX_HOLD-1, other req bits set: grant SHALL move to next requester per search from owner+1 in the same edge; ptr <= owner+1.
REQ-016 OWN, req[owner]==1, hc==MAX_HOLD-1, no other req: owner SHALL keep the grant, hc reset to 0, sw stays 0.
REQ-017 OWN, req[owner]==1, hc<MAX_HOLD-1: grant SHALL be unchanged regardless of other requests.
REQ-018 sw SHALL be 1 exactly for the cycle following an edge that loads a new owner (including IDLE->OWN and owner-to-owner handoff), 0 otherwise.
REQ-019 busy SHALL equal (gnt != 0) at all times.
REQ-020 MAX_HOLD=1: every cycle with competing requests SHALL rotate the grant.
REQ-021 Requests asserted in the same cycle as a release SHALL be considered in that edge's arbitration.

Reset
REQ-022 While rst=1 at an edge: gnt=0, s=0, busy=0, sw=0, ptr=0, hc=0, state IDLE; req ignored.
REQ-023 Reset asserted mid-grant SHALL drop gnt on that edge; first arbitration after reset SHALL start from ptr=0.

Verification
REQ-024 Reset then req=8'h00 for 5 cycles -> gnt=0, s=0, busy=0, sw=0 throughout.
REQ-025 req=8'h24 from IDLE, ptr=0 -> next edge gnt=8'h04, s=2, sw=1 one cycle; req[2] held, req[5] held, MAX_HOLD=4 -> after 4 owned cycles gnt=8'h20, s=5, sw=1.
REQ-026 req=8'h80 only, held 10 cycles -> gnt=8'h80, s=7 continuously, sw pulses once; drop req -> gnt=0, busy=0, s stays 7.
REQ-027 Wrap: owner 7 releases with req=8'h03 -> next edge gnt=8'h01, s=0 (ptr wrapped to 0); owner 0 releases with req=8'h02 -> gnt=8'h02.
REQ-028 req=8'hFF held, MAX_HOLD=1 -> s sequence 0,1,2,...,7,0 on successive cycles, sw=1 every cycle.
REQ-029 rst=1 during grant of owner 5 -> next edge gnt=0, s=0; rst=0 with req=8'hFF -> gnt=8'h01.

Source files
------------

// File: rtl/mux8_rr_arb.sv
// mux8_rr_arb
//   Round-robin arbiter for a shared 8-to-1, 8-bit mux path.
//   Each requester keeps the grant for at most MAX_HOLD consecutive cycles
//   while other requesters are waiting. The mux select stays put while idle
//   so the mux output does not glitch.
//
// Ports
//   clk   in   1  system clock, rising-edge
//   rst   in   1  synchronous active-high reset
//   req   in   8  request lines, bit i = requester i
//   gnt   out  8  registered one-hot grant (0 when idle)
//   s     out  3  registered mux select = index of current/last owner
//   busy  out  1  registered, 1 while a grant is held
//   sw    out  1  registered one-cycle pulse when a new owner is loaded
module mux8_rr_arb #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] s,
  output logic       busy,
  output logic       sw
);

  typedef enum logic {
    ST_IDLE,
    ST_OWN
  } state_t;

  localparam logic [7:0] HC_LAST = 8'(MAX_HOLD - 1);

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_hc;
  logic [7:0] r_gnt;
  logic [2:0] r_s;
  logic       r_busy;
  logic       r_sw;

  logic [2:0] w_base;
  logic [7:0] w_cand;
  logic [2:0] w_idx;
  logic [2:0] w_pick;
  logic       w_found;

  // While owning, the search always starts just past the owner: that is the
  // updated pointer on a release and the rotation start on hold expiry.
  // The current owner is masked out so a rotation never re-picks it.
  always_comb begin
    w_base  = (r_state == ST_OWN) ? (r_s + 3'd1) : r_ptr;
    w_cand  = req & ~r_gnt;
    w_found = 1'b0;
    w_pick  = w_base;
    w_idx   = '0;
    // Walk from the far end back so the index nearest w_base wins.
    for (int k = 7; k >= 0; k--) begin
      w_idx = w_base + 3'(k);
      if (w_cand[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_hc    <= '0;
      r_gnt   <= '0;
      r_s     <= '0;
      r_busy  <= 1'b0;
      r_sw    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_sw <= 1'b0;
          if (w_found) begin
            r_state <= ST_OWN;
            r_gnt   <= 8'd1 << w_pick;
            r_s     <= w_pick;
            r_busy  <= 1'b1;
            r_sw    <= 1'b1;
            r_hc    <= '0;
          end
        end
        ST_OWN: begin
          r_sw <= 1'b0;
          if (!req[r_s]) begin
            // Owner let go: advance priority past it and hand over at once.
            r_ptr <= r_s + 3'd1;
            if (w_found) begin
              r_gnt <= 8'd1 << w_pick;
              r_s   <= w_pick;
              r_sw  <= 1'b1;
              r_hc  <= '0;
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= '0;
              r_busy  <= 1'b0;
              r_hc    <= '0;
            end
          end else if (r_hc == HC_LAST) begin
            // Hold budget spent: rotate if anyone else waits, else renew.
            r_hc <= '0;
            if (w_found) begin
              r_ptr <= r_s + 3'd1;
              r_gnt <= 8'd1 << w_pick;
              r_s   <= w_pick;
              r_sw  <= 1'b1;
            end
          end else begin
            r_hc <= r_hc + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_sw    <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign s    = r_s;
  assign busy = r_busy;
  assign sw   = r_sw;

endmodule

// File: tb/tb_mux8_rr_arb.sv
// Testbench for mux8_rr_arb: two instances (MAX_HOLD=4 and MAX_HOLD=1)
// share clock, reset and requests; both are checked against a behavioural
// model of the arbitration rules.
module tb_mux8_rr_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;

  logic [7:0] gnt_a, gnt_b;
  logic [2:0] s_a, s_b;
  logic       busy_a, busy_b, sw_a, sw_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux8_rr_arb #(.MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_a), .s(s_a), .busy(busy_a), .sw(sw_a)
  );

  mux8_rr_arb #(.MAX_HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_b), .s(s_b), .busy(busy_b), .sw(sw_b)
  );

  // Model state per instance: owner (-1 = nobody), last select, priority
  // pointer, cycles already held, and the switch pulse.
  int m_own [2] = '{-1, -1};
  int m_last[2] = '{0, 0};
  int m_ptr [2] = '{0, 0};
  int m_hc  [2] = '{0, 0};
  bit m_sw  [2] = '{0, 0};
  int m_mh  [2] = '{4, 1};

  function automatic int first_from(int base, logic [7:0] mask);
    for (int k = 0; k < 8; k++) begin
      if (mask[(base + k) % 8]) return (base + k) % 8;
    end
    return -1;
  endfunction

  function automatic void model_edge(int k, logic [7:0] r, bit rs);
    int p;
    m_sw[k] = 1'b0;
    if (rs) begin
      m_own[k] = -1; m_last[k] = 0; m_ptr[k] = 0; m_hc[k] = 0;
    end else if (m_own[k] < 0) begin
      p = first_from(m_ptr[k], r);
      if (p >= 0) begin
        m_own[k] = p; m_last[k] = p; m_hc[k] = 0; m_sw[k] = 1'b1;
      end
    end else if (!r[m_own[k]]) begin
      m_ptr[k] = (m_own[k] + 1) % 8;
      p = first_from(m_ptr[k], r);
      if (p >= 0) begin
        m_own[k] = p; m_last[k] = p; m_hc[k] = 0; m_sw[k] = 1'b1;
      end else begin
        m_own[k] = -1; m_hc[k] = 0;
      end
    end else if (m_hc[k] == m_mh[k] - 1) begin
      p = first_from(m_own[k] + 1, r & ~(8'd1 << m_own[k]));
      m_hc[k] = 0;
      if (p >= 0) begin
        m_ptr[k] = (m_own[k] + 1) % 8;
        m_own[k] = p; m_last[k] = p; m_sw[k] = 1'b1;
      end
    end else begin
      m_hc[k] = m_hc[k] + 1;
    end
  endfunction

  // Expected {gnt, s, busy, sw}
  function automatic logic [12:0] exp_vec(int k);
    logic [7:0] g;
    g = (m_own[k] < 0) ? 8'h00 : (8'd1 << m_own[k]);
    return {g, 3'(m_last[k]), (m_own[k] >= 0), m_sw[k]};
  endfunction

  function automatic logic [12:0] obs_vec(int k);
    return (k == 0) ? {gnt_a, s_a, busy_a, sw_a} : {gnt_b, s_b, busy_b, sw_b};
  endfunction

  // Drive one cycle of stimulus, advance the model, settle after the edge.
  task automatic tick(input logic [7:0] r, input bit rs);
    @(negedge clk);
    req = r;
    rst = rs;
    @(posedge clk);
    model_edge(0, r, rs);
    model_edge(1, r, rs);
    #1;
  endtask

  task automatic test_reset();
    tick(8'h5A, 1'b1);
    tick(8'hFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(8'h00, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs_vec(k) !== 13'h0) begin
          n_err++;
          $display("FAIL reset_idle inst%0d cyc%0d got=%h want=%h", k, i, obs_vec(k), 13'h0);
        end
      end
    end
  endtask

  task automatic test_hold_rotate();
    tick(8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(8'h24, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL hold_rotate inst%0d cyc%0d got=%h want=%h", k, i, obs_vec(k), exp_vec(k));
        end
      end
      // MAX_HOLD=4: four owned cycles for requester 2, then requester 5.
      n_vec++;
      if (i < 4 && (gnt_a !== 8'h04 || s_a !== 3'd2 || sw_a !== (i == 0))) begin
        n_err++;
        $display("FAIL hold_first cyc%0d got gnt=%h s=%0d sw=%b want gnt=04 s=2", i, gnt_a, s_a, sw_a);
      end else if (i == 4 && (gnt_a !== 8'h20 || s_a !== 3'd5 || sw_a !== 1'b1)) begin
        n_err++;
        $display("FAIL hold_switch got gnt=%h s=%0d sw=%b want gnt=20 s=5 sw=1", gnt_a, s_a, sw_a);
      end
    end
  endtask

  task automatic test_single();
    int pulses = 0;
    tick(8'h00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(8'h80, 1'b0);
      pulses += int'(sw_a);
      n_vec++;
      if (gnt_a !== 8'h80 || s_a !== 3'd7 || busy_a !== 1'b1) begin
        n_err++;
        $display("FAIL single_hold cyc%0d got gnt=%h s=%0d busy=%b want gnt=80 s=7 busy=1", i, gnt_a, s_a, busy_a);
      end
      n_vec++;
      if (obs_vec(1) !== exp_vec(1)) begin
        n_err++;
        $display("FAIL single_hold inst1 cyc%0d got=%h want=%h", i, obs_vec(1), exp_vec(1));
      end
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL single_sw_pulses got=%0d want=1", pulses);
    end
    tick(8'h00, 1'b0);
    n_vec++;
    if (gnt_a !== 8'h00 || busy_a !== 1'b0 || s_a !== 3'd7 || sw_a !== 1'b0) begin
      n_err++;
      $display("FAIL single_drop got gnt=%h busy=%b s=%0d sw=%b want gnt=00 busy=0 s=7 sw=0", gnt_a, busy_a, s_a, sw_a);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] seq [3] = '{8'h80, 8'h03, 8'h02};
    logic [7:0] want_g [3] = '{8'h80, 8'h01, 8'h02};
    for (int i = 0; i < 3; i++) begin
      tick(seq[i], 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL wrap inst%0d step%0d got=%h want=%h", k, i, obs_vec(k), exp_vec(k));
        end
      end
      n_vec++;
      if (gnt_a !== want_g[i] || sw_a !== 1'b1) begin
        n_err++;
        $display("FAIL wrap_gnt step%0d got gnt=%h sw=%b want gnt=%h sw=1", i, gnt_a, sw_a, want_g[i]);
      end
    end
  endtask

  task automatic test_rotate_all();
    tick(8'h00, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick(8'hFF, 1'b0);
      n_vec++;
      if (s_b !== 3'(i % 8) || sw_b !== 1'b1 || gnt_b !== (8'd1 << (i % 8))) begin
        n_err++;
        $display("FAIL rotate_mh1 cyc%0d got s=%0d sw=%b gnt=%h want s=%0d sw=1", i, s_b, sw_b, gnt_b, i % 8);
      end
      n_vec++;
      if (obs_vec(0) !== exp_vec(0)) begin
        n_err++;
        $display("FAIL rotate_mh4 cyc%0d got=%h want=%h", i, obs_vec(0), exp_vec(0));
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(8'h00, 1'b1);
    tick(8'h20, 1'b0);
    tick(8'h20, 1'b1);
    n_vec++;
    if (gnt_a !== 8'h00 || s_a !== 3'd0 || busy_a !== 1'b0 || gnt_b !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid got gnt=%h s=%0d busy=%b want gnt=00 s=0 busy=0", gnt_a, s_a, busy_a);
    end
    tick(8'hFF, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs_vec(k) !== {8'h01, 3'd0, 1'b1, 1'b1}) begin
        n_err++;
        $display("FAIL reset_restart inst%0d got=%h want=%h", k, obs_vec(k), {8'h01, 3'd0, 1'b1, 1'b1});
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    bit rs;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: r = 8'h00;
        1: r = 8'd1 << $urandom_range(0, 7);
        2: r = 8'($urandom) & 8'($urandom);
        default: r = 8'($urandom);
      endcase
      rs = ($urandom_range(0, 49) == 0);
      tick(r, rs);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL random inst%0d cyc%0d req=%h got=%h want=%h", k, i, r, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold_rotate();
    test_single();
    test_wrap();
    test_rotate_all();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
